// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule block.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // LOAD passes message words M[0..15] through; EXPAND generates W[16..63].
    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    localparam int BLOCK_WORDS = 16;
    localparam int SCHED_WORDS = 64;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: ROTR(a) ^ ROTR(b) ^ SHR(s) on one 32-bit word.
// s0 uses (7, 18, 3); s1 uses (17, 19, 10).
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned ROT_A = 7,
    parameter int unsigned ROT_B = 18,
    parameter int unsigned SHR   = 3
) (
    input  word_t i_x,
    output word_t o_y
);

    word_t w_rot_a;
    word_t w_rot_b;
    word_t w_shr;

    // Right rotations are plain rewiring; the shift fills with zeros.
    assign w_rot_a = {i_x[ROT_A-1:0], i_x[31:ROT_A]};
    assign w_rot_b = {i_x[ROT_B-1:0], i_x[31:ROT_B]};
    assign w_shr   = i_x >> SHR;
    assign o_y     = w_rot_a ^ w_rot_b ^ w_shr;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts M[0..15], emits W[0..63] through a
// single output register with valid/ready handshake on both sides.
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last
);

    localparam logic [5:0] T_LAST_MSG  = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] T_LAST_SCHED = 6'(SCHED_WORDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_t;
    // r_win[0] is W[t-16] (oldest), r_win[15] is W[t-1] (newest).
    word_t       r_win [BLOCK_WORDS];
    logic        r_out_valid;
    word_t       r_out_word;
    logic [5:0]  r_out_idx;
    logic        r_out_last;

    logic        w_slot_free;
    logic        w_in_ready;
    logic        w_load;
    word_t       w_new_word;
    word_t       w_s0;
    word_t       w_s1;
    word_t       w_sum;

    sha256_small_sigma #(.ROT_A(7),  .ROT_B(18), .SHR(3))  u_s0 (.i_x(r_win[1]),  .o_y(w_s0));
    sha256_small_sigma #(.ROT_A(17), .ROT_B(19), .SHR(10)) u_s1 (.i_x(r_win[14]), .o_y(w_s1));

    // s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]; the 32-bit result drops the carry.
    assign w_sum = w_s1 + r_win[9] + w_s0 + r_win[0];

    // The output register can take a new word when empty or being drained.
    assign w_slot_free = !r_out_valid || out_ready;

    // Next-state, handshake and word-source selection.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        w_new_word   = in_word;
        case (r_state)
            ST_LOAD: begin
                w_in_ready = w_slot_free;
                w_load     = in_valid && w_slot_free;
                w_new_word = in_word;
                if (w_load && (r_t == T_LAST_MSG)) begin
                    w_state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_load     = w_slot_free;
                w_new_word = w_sum;
                if (w_load && (r_t == T_LAST_SCHED)) begin
                    w_state_next = ST_LOAD;
                end
            end
            default: begin
                w_state_next = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Word counter; wraps 63 -> 0 naturally at the end of a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t <= '0;
        end else if (w_load) begin
            r_t <= r_t + 6'd1;
        end
    end

    // Sliding window of the last 16 schedule words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[BLOCK_WORDS-1] <= w_new_word;
        end
    end

    // Output register: a load wins over a drain, so valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_word  <= w_new_word;
            r_out_idx   <= r_t;
            r_out_last  <= (r_t == T_LAST_SCHED);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule
